// File: rtl/ps2_key_event.sv
// PS/2 Set 2 scan-code interpreter: pops bytes from the receiver FIFO, resolves E0/F0
// prefixes, filters typematic repeats and emits registered press/release events.
module ps2_key_event #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [7:0]       data,
   input  logic             ready,
   input  logic             overflow,
   output logic             nextdata_n,
   output logic             fifo_clr_n,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic             key_down,
   output logic [7:0]       ascii,
   output logic             evt_valid,
   output logic             rel_valid,
   output logic [CNT_W-1:0] press_count,
   output logic             err
);

   typedef enum logic [1:0] {IDLE, POP, SETTLE, FLUSH} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [7:0]       byte_q, byte_d;
   logic             ext_pend_q, ext_pend_d;
   logic             brk_pend_q, brk_pend_d;
   logic             nextdata_n_q, nextdata_n_d;
   logic             fifo_clr_n_q, fifo_clr_n_d;
   logic [7:0]       key_code_q, key_code_d;
   logic             key_ext_q, key_ext_d;
   logic             key_down_q, key_down_d;
   logic [7:0]       ascii_q, ascii_d;
   logic             evt_valid_q, evt_valid_d;
   logic             rel_valid_q, rel_valid_d;
   logic [CNT_W-1:0] press_count_q, press_count_d;
   logic             err_q, err_d;
   logic             same_key;

   function automatic logic [7:0] scan_to_ascii(input logic [7:0] sc);
      case (sc)
         8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63; 8'h23: return 8'h64;
         8'h24: return 8'h65; 8'h2B: return 8'h66; 8'h34: return 8'h67; 8'h33: return 8'h68;
         8'h43: return 8'h69; 8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
         8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F; 8'h4D: return 8'h70;
         8'h15: return 8'h71; 8'h2D: return 8'h72; 8'h1B: return 8'h73; 8'h2C: return 8'h74;
         8'h3C: return 8'h75; 8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
         8'h35: return 8'h79; 8'h1A: return 8'h7A;
         8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32; 8'h26: return 8'h33;
         8'h25: return 8'h34; 8'h2E: return 8'h35; 8'h36: return 8'h36; 8'h3D: return 8'h37;
         8'h3E: return 8'h38; 8'h46: return 8'h39;
         8'h29: return 8'h20; 8'h5A: return 8'h0D;
         default: return 8'h00;
      endcase
   endfunction

   always_comb begin
      state_d       = state_q;
      byte_d        = byte_q;
      ext_pend_d    = ext_pend_q;
      brk_pend_d    = brk_pend_q;
      nextdata_n_d  = 1'b1;
      fifo_clr_n_d  = 1'b1;
      key_code_d    = key_code_q;
      key_ext_d     = key_ext_q;
      key_down_d    = key_down_q;
      ascii_d       = ascii_q;
      evt_valid_d   = 1'b0;
      rel_valid_d   = 1'b0;
      press_count_d = press_count_q;
      err_d         = err_q;
      same_key      = key_down_q && (byte_q == key_code_q) && (ext_pend_q == key_ext_q);

      // Overflow in any active state discards the byte in flight and clears the receiver.
      if (overflow && state_q != FLUSH) begin
         state_d      = FLUSH;
         fifo_clr_n_d = 1'b0;
         err_d        = 1'b1;
         ext_pend_d   = 1'b0;
         brk_pend_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ready) begin
                  byte_d       = data;
                  nextdata_n_d = 1'b0;
                  state_d      = POP;
               end
            end
            POP: begin
               state_d = SETTLE;
               if (byte_q == 8'hE0) begin
                  ext_pend_d = 1'b1;
               end else if (byte_q == 8'hF0) begin
                  brk_pend_d = 1'b1;
               end else begin
                  ext_pend_d = 1'b0;
                  brk_pend_d = 1'b0;
                  if (brk_pend_q) begin
                     if (same_key) begin
                        key_down_d  = 1'b0;
                        rel_valid_d = 1'b1;
                     end
                  end else if (!same_key) begin
                     key_code_d    = byte_q;
                     key_ext_d     = ext_pend_q;
                     key_down_d    = 1'b1;
                     ascii_d       = ext_pend_q ? 8'h00 : scan_to_ascii(byte_q);
                     press_count_d = press_count_q + CNT_ONE;
                     evt_valid_d   = 1'b1;
                  end
               end
            end
            SETTLE:  state_d = IDLE;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q       <= IDLE;
         byte_q        <= '0;
         ext_pend_q    <= 1'b0;
         brk_pend_q    <= 1'b0;
         nextdata_n_q  <= 1'b1;
         fifo_clr_n_q  <= 1'b0;
         key_code_q    <= '0;
         key_ext_q     <= 1'b0;
         key_down_q    <= 1'b0;
         ascii_q       <= '0;
         evt_valid_q   <= 1'b0;
         rel_valid_q   <= 1'b0;
         press_count_q <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_q        <= byte_d;
         ext_pend_q    <= ext_pend_d;
         brk_pend_q    <= brk_pend_d;
         nextdata_n_q  <= nextdata_n_d;
         fifo_clr_n_q  <= fifo_clr_n_d;
         key_code_q    <= key_code_d;
         key_ext_q     <= key_ext_d;
         key_down_q    <= key_down_d;
         ascii_q       <= ascii_d;
         evt_valid_q   <= evt_valid_d;
         rel_valid_q   <= rel_valid_d;
         press_count_q <= press_count_d;
         err_q         <= err_d;
      end
   end

   assign nextdata_n  = nextdata_n_q;
   assign fifo_clr_n  = fifo_clr_n_q;
   assign key_code    = key_code_q;
   assign key_ext     = key_ext_q;
   assign key_down    = key_down_q;
   assign ascii       = ascii_q;
   assign evt_valid   = evt_valid_q;
   assign rel_valid   = rel_valid_q;
   assign press_count = press_count_q;
   assign err         = err_q;

endmodule

// File: tb/tb_ps2_key_event.sv
// Bench for ps2_key_event: emulates the receiver FIFO and checks every cycle against a
// key-level reference model of the scan-code rules.
module tb_ps2_key_event;

   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          clrn = 1'b1;
   logic [7:0]    data = 8'h00;
   logic          ready = 1'b0;
   logic          overflow = 1'b0;
   logic          nextdata_n, fifo_clr_n, key_ext, key_down, evt_valid, rel_valid, err;
   logic [7:0]    key_code, ascii;
   logic [CW-1:0] press_count;

   ps2_key_event #(.CNT_W(CW)) dut (
      .clk(clk), .clrn(clrn), .data(data), .ready(ready), .overflow(overflow),
      .nextdata_n(nextdata_n), .fifo_clr_n(fifo_clr_n), .key_code(key_code),
      .key_ext(key_ext), .key_down(key_down), .ascii(ascii), .evt_valid(evt_valid),
      .rel_valid(rel_valid), .press_count(press_count), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] fifo_q[$];

   logic        m_ext, m_brk, m_down, m_kext, m_err;
   logic [7:0]  m_code;
   int unsigned m_presses;
   int          evt_seen, rel_seen, pop_seen, pops_started, ovf_at;
   logic        prev_nd;

   byte unsigned letter_sc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                   8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                   8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                   8'h35, 8'h1A};
   byte unsigned digit_sc[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                  8'h3E, 8'h46};

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic e);
      if (e) return 8'h00;
      for (int i = 0; i < 26; i++) if (letter_sc[i] == c) return 8'(8'h61 + i);
      for (int i = 0; i < 10; i++) if (digit_sc[i] == c) return 8'(8'h30 + i);
      if (c == 8'h29) return 8'h20;
      if (c == 8'h5A) return 8'h0D;
      return 8'h00;
   endfunction

   task automatic model_byte(input logic [7:0] b, output logic evt, output logic rel);
      logic held;
      evt = 1'b0;
      rel = 1'b0;
      held = m_down && (b == m_code) && (m_ext == m_kext);
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         if (m_brk) begin
            if (held) begin m_down = 1'b0; rel = 1'b1; end
         end else if (!held) begin
            m_code = b; m_kext = m_ext; m_down = 1'b1; m_presses++; evt = 1'b1;
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic drive_fifo();
      ready = (fifo_q.size() != 0);
      data  = ready ? fifo_q[0] : 8'h00;
   endtask

   task automatic push(input logic [7:0] b);
      fifo_q.push_back(b);
      drive_fifo();
   endtask

   task automatic cycle();
      logic pop_req, ovf_b, e_evt, e_rel;
      logic [7:0] b;
      pop_req = (nextdata_n === 1'b0);
      ovf_b   = overflow;
      @(posedge clk);
      #1;
      e_evt = 1'b0;
      e_rel = 1'b0;
      b = 8'h00;
      if (pop_req) begin
         pop_seen++;
         if (fifo_q.size() != 0) b = fifo_q.pop_front();
      end
      if (ovf_b) begin
         m_err = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
      end else if (pop_req) begin
         model_byte(b, e_evt, e_rel);
      end
      chk("evt_valid", 32'(evt_valid), 32'(e_evt));
      chk("rel_valid", 32'(rel_valid), 32'(e_rel));
      chk("fifo_clr_n", 32'(fifo_clr_n), 32'(!ovf_b));
      chk("err", 32'(err), 32'(m_err));
      chk("key_code", 32'(key_code), 32'(m_code));
      chk("key_ext", 32'(key_ext), 32'(m_kext));
      chk("key_down", 32'(key_down), 32'(m_down));
      chk("ascii", 32'(ascii), 32'(m_presses == 0 ? 8'h00 : ref_ascii(m_code, m_kext)));
      chk("press_count", 32'(press_count), m_presses % (32'd1 << CW));
      if (evt_valid === 1'b1) evt_seen++;
      if (rel_valid === 1'b1) rel_seen++;
      if (nextdata_n === 1'b0) begin
         chk("nd_gap", 32'(prev_nd), 32'd1);
         chk("nd_ovf", 32'(ovf_b), 32'd0);
         if (pops_started == ovf_at) overflow = 1'b1;
         pops_started++;
      end
      prev_nd = nextdata_n;
      if (fifo_clr_n === 1'b0) begin
         fifo_q.delete();
         overflow = 1'b0;
      end
      drive_fifo();
   endtask

   task automatic drain();
      int n = 0;
      while ((fifo_q.size() != 0 || nextdata_n !== 1'b1) && n < 300) begin
         cycle();
         n++;
      end
      chk("drain_timeout", 32'(n < 300), 32'd1);
      repeat (3) cycle();
   endtask

   task automatic clr_counts();
      evt_seen = 0; rel_seen = 0; pop_seen = 0;
   endtask

   task automatic do_reset();
      #2;
      clrn = 1'b0;
      fifo_q.delete();
      overflow = 1'b0;
      drive_fifo();
      m_ext = 1'b0; m_brk = 1'b0; m_down = 1'b0; m_kext = 1'b0; m_err = 1'b0;
      m_code = 8'h00; m_presses = 0; ovf_at = -1; pops_started = 0;
      #1;
      chk("rst_nextdata_n", 32'(nextdata_n), 32'd1);
      chk("rst_fifo_clr_n", 32'(fifo_clr_n), 32'd0);
      chk("rst_key_code", 32'(key_code), 32'd0);
      chk("rst_key_ext", 32'(key_ext), 32'd0);
      chk("rst_key_down", 32'(key_down), 32'd0);
      chk("rst_ascii", 32'(ascii), 32'd0);
      chk("rst_evt", 32'(evt_valid), 32'd0);
      chk("rst_rel", 32'(rel_valid), 32'd0);
      chk("rst_press_count", 32'(press_count), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(negedge clk);
      clrn = 1'b1;
      #1;
      chk("rst_clr_hold", 32'(fifo_clr_n), 32'd0);
      prev_nd = 1'b1;
      clr_counts();
      cycle();
   endtask

   function automatic logic [7:0] pick_key();
      case ($urandom_range(0, 3))
         0:       return letter_sc[$urandom_range(0, 25)];
         1:       return digit_sc[$urandom_range(0, 9)];
         2:       return ($urandom_range(0, 1) != 0) ? 8'h29 : 8'h5A;
         default: return 8'($urandom_range(1, 127));
      endcase
   endfunction

   initial begin
      logic [7:0] cur;
      logic       cur_e;
      int         n;

      do_reset();

      // Reset asserted while a byte is in POP.
      push(8'h1C);
      n = 0;
      while (nextdata_n !== 1'b0 && n < 20) begin cycle(); n++; end
      chk("midpop_reach", 32'(n < 20), 32'd1);
      do_reset();
      drain();

      // Single press.
      do_reset();
      push(8'h1C);
      drain();
      chk("single_code", 32'(key_code), 32'h1C);
      chk("single_ascii", 32'(ascii), 32'h61);
      chk("single_down", 32'(key_down), 32'd1);
      chk("single_count", 32'(press_count), 32'd1);
      chk("single_evts", 32'(evt_seen), 32'd1);
      chk("single_pops", 32'(pop_seen), 32'd1);

      // Typematic repeats then release.
      do_reset();
      foreach (letter_sc[i]) if (i < 3) push(8'h1C);
      push(8'hF0); push(8'h1C);
      drain();
      chk("typ_evts", 32'(evt_seen), 32'd1);
      chk("typ_rels", 32'(rel_seen), 32'd1);
      chk("typ_pops", 32'(pop_seen), 32'd5);
      chk("typ_count", 32'(press_count), 32'd1);
      chk("typ_down", 32'(key_down), 32'd0);

      // Extended press/release, then plain break of an extended key.
      do_reset();
      push(8'hE0); push(8'h75);
      drain();
      chk("ext_flag", 32'(key_ext), 32'd1);
      chk("ext_code", 32'(key_code), 32'h75);
      chk("ext_ascii", 32'(ascii), 32'h00);
      chk("ext_count", 32'(press_count), 32'd1);
      clr_counts();
      push(8'hE0); push(8'hF0); push(8'h75);
      drain();
      chk("ext_rel", 32'(rel_seen), 32'd1);
      push(8'hE0); push(8'h75);
      drain();
      clr_counts();
      push(8'hF0); push(8'h75);
      drain();
      chk("ext_plain_rel", 32'(rel_seen), 32'd0);
      chk("ext_plain_down", 32'(key_down), 32'd1);

      // Break code for a key that is not held.
      do_reset();
      push(8'h1C); push(8'hF0); push(8'h32);
      drain();
      chk("mis_rel", 32'(rel_seen), 32'd0);
      chk("mis_down", 32'(key_down), 32'd1);
      clr_counts();
      push(8'h45);
      drain();
      chk("mis_evt", 32'(evt_seen), 32'd1);
      chk("mis_ascii", 32'(ascii), 32'h30);
      chk("mis_count", 32'(press_count), 32'd2);

      // Overflow during POP of 1C with E0 pending.
      do_reset();
      ovf_at = 1;
      push(8'hE0); push(8'h1C);
      drain();
      chk("ovf_err", 32'(err), 32'd1);
      chk("ovf_count", 32'(press_count), 32'd0);
      chk("ovf_down", 32'(key_down), 32'd0);
      push(8'h1C);
      drain();
      chk("ovf_ext_cleared", 32'(key_ext), 32'd0);
      chk("ovf_after_count", 32'(press_count), 32'd1);
      chk("ovf_err_sticky", 32'(err), 32'd1);

      // Counter wrap with a 2-bit counter.
      do_reset();
      push(8'h1C); push(8'h32); push(8'h21); push(8'h23); push(8'h24);
      drain();
      chk("wrap_count", 32'(press_count), 32'd1);
      chk("wrap_evts", 32'(evt_seen), 32'd5);

      // Randomized key activity.
      do_reset();
      cur = 8'h1C;
      cur_e = 1'b0;
      repeat (120) begin
         case ($urandom_range(0, 8))
            0, 1, 2: begin
               cur = pick_key();
               cur_e = ($urandom_range(0, 1) != 0);
               if (cur_e) push(8'hE0);
               push(cur);
            end
            3: begin
               if (cur_e) push(8'hE0);
               push(cur);
            end
            4: begin
               if ($urandom_range(0, 1) != 0) begin
                  if (cur_e) push(8'hE0);
                  push(8'hF0);
               end else begin
                  push(8'hF0);
                  if (cur_e) push(8'hE0);
               end
               push(cur);
            end
            5: begin push(8'hF0); push(cur ^ 8'h01); end
            6: push(8'($urandom_range(0, 255)));
            7: begin
               ovf_at = pops_started + int'($urandom_range(0, 2));
               push(pick_key());
            end
            default: repeat ($urandom_range(1, 4)) cycle();
         endcase
         if ($urandom_range(0, 2) == 0) drain();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_key_event.md
# ps2_key_event

Scan-code interpreter sitting directly downstream of the `ps2_keyboard` receiver FIFO and upstream of the counter/BCD/`digital_led` display path. It pops PS/2 Scan Code Set 2 bytes from the receiver, resolves `E0` (extended) and `F0` (break) prefixes, and suppresses typematic repeats. It emits one-cycle press/release events together with the current key code, its ASCII translation and a running press count. It also owns FIFO flow control: the pop strobe and the overflow-recovery clear.

## Interface
- `CNT_W`, 8: width of `press_count`; wraps modulo 2^CNT_W.

- `clk` in 1: system clock, rising edge.
- `clrn` in 1: asynchronous active-low reset.
- `data` in 8: byte at the receiver FIFO head; valid while `ready`=1.
- `ready` in 1: receiver FIFO non-empty.
- `overflow` in 1: receiver FIFO overflow flag.
- `nextdata_n` out 1: active-low pop strobe to the receiver, exactly one cycle per consumed byte.
- `fifo_clr_n` out 1: active-low clear to the receiver's `clrn`.
- `key_code` out 8: scan code of the last pressed key (prefixes stripped).
- `key_ext` out 1: last pressed key was `E0`-prefixed.
- `key_down` out 1: level, high while that key is held.
- `ascii` out 8: ASCII code of `key_code`, or 0x00 if unmapped or extended.
- `evt_valid` out 1: one-cycle pulse on a new press.
- `rel_valid` out 1: one-cycle pulse on release of the held key.
- `press_count` out CNT_W: number of new presses since reset.
- `err` out 1: sticky, set on any overflow; cleared only by reset.

## Operation
- FSM states: IDLE, POP, SETTLE, FLUSH.
- Internal flags: `ext_pend`, `brk_pend`, byte register `byte_r`.
- **IDLE**
  - `overflow`=1 → FLUSH.
  - Else `ready`=1 → latch `data` into `byte_r`, drive `nextdata_n`=0, go to POP.
- **POP**
  - `nextdata_n`=1.
  - If `overflow`=1 → discard `byte_r`, go to FLUSH.
  - Else process `byte_r`, go to SETTLE.
- **SETTLE**: one idle cycle so the receiver's `ready`/`data` reflect the pop; then IDLE. `overflow`=1 here → FLUSH.
- **FLUSH**
  - `fifo_clr_n`=0 for exactly one cycle, then IDLE.
  - Sets `err`; clears `ext_pend` and `brk_pend`.
  - `key_*` outputs and `press_count` are unchanged.
- **Byte processing**
  - `E0`: set `ext_pend`.
  - `F0`: set `brk_pend`. Prefixes accumulate in either order (`E0 F0 xx` is the extended break form).
  - Any other code c with `brk_pend`=1:
    - If `key_down`=1, c==`key_code` and `ext_pend`==`key_ext`: `key_down`←0, pulse `rel_valid`.
    - Otherwise ignore.
    - Clear both flags.
  - Any other code c with `brk_pend`=0:
    - If `key_down`=1, c==`key_code` and `ext_pend`==`key_ext`: typematic repeat; no event, no count.
    - Otherwise: `key_code`←c, `key_ext`←`ext_pend`, `key_down`←1, `ascii`←lookup, `press_count`+1 (wrapping), pulse `evt_valid`.
    - Clear both flags.
- **ASCII lookup** (non-extended only):
  - Letters map to lowercase: 1C→61, 32→62, … 1A→7A.
  - Digits: 45→30, 16→31, … 46→39.
  - 29→20, 5A→0D.
  - Everything else → 00.

## Timing
- Reset (async, `clrn`=0):
  - State IDLE, `nextdata_n`=1, `fifo_clr_n`=0.
  - `key_code`=00, `key_ext`=0, `key_down`=0, `ascii`=00, `evt_valid`=0, `rel_valid`=0, `press_count`=0, `err`=0, flags clear.
  - First edge after release: `fifo_clr_n`→1, which flushes the receiver at power-up.
- Reset asserted mid-sequence (any state, pending prefixes) returns everything to the above immediately; no pulse completes.
- All outputs are registered.
- Byte cadence: `ready` seen at edge N → `nextdata_n`=0 during [N, N+1).
- At N+1: outputs updated and `evt_valid`/`rel_valid` high during [N+1, N+2); SETTLE.
- At N+2: IDLE, pulses low.
- Maximum throughput: 1 byte per 3 cycles.
- `nextdata_n` is never low in consecutive cycles and never low while `overflow`=1 is sampled in IDLE.
- `evt_valid` and `rel_valid` are never high in the same cycle.
- `overflow` takes priority over `ready` in every state.
- `press_count` at 2^CNT_W−1 wraps to 0 on the next press, with `evt_valid` still pulsed.

## Test plan
- **Reset:** hold `clrn`=0 mid-POP → all outputs at their reset values; after release, `fifo_clr_n`=0 for exactly one cycle and `nextdata_n`=1.
- **Single press:** FIFO bytes `1C` → `nextdata_n` low 1 cycle; next cycle `evt_valid`=1, `key_code`=1C, `ascii`=61, `key_down`=1, `press_count`=1.
- **Typematic and release:** `1C 1C 1C F0 1C` → one `evt_valid`, `press_count`=1, one `rel_valid`, `key_down`=0, five pop strobes.
- **Extended key:** `E0 75` → `key_ext`=1, `key_code`=75, `ascii`=00, `press_count`+1. Then `E0 F0 75` → `rel_valid`. Plain `F0 75` instead → no `rel_valid`.
- **Mismatched release:** press `1C` then `F0 32` → no `rel_valid`, `key_down` stays 1. Then `45` → `evt_valid`, `ascii`=30, `press_count`=2.
- **Overflow:** raise `overflow` during POP of `1C` → byte dropped, `fifo_clr_n` low 1 cycle, `err`=1 sticky, `press_count` unchanged, `E0` pending before the overflow is cleared. With `CNT_W`=2, five distinct presses → `press_count`=1.
